// File: rtl/intr_pkg.sv
// intr_pkg: shared sizes and FSM state encoding for the interrupt pending controller.
package intr_pkg;
   localparam int NUM_IRQ = 128;
   localparam int ID_W    = $clog2(NUM_IRQ);
   typedef enum logic {IRQ_IDLE = 1'b0, IRQ_REQ = 1'b1} irq_state_e;
endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: lowest-index-first priority encoder with found flag.
module intr_prio_enc
   import intr_pkg::*;
(
   input  logic [NUM_IRQ-1:0] i_vec,
   output logic [ID_W-1:0]    o_id,
   output logic               o_found
);
   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      o_id    = '0;
      o_found = 1'b0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (i_vec[k]) begin
            o_id    = ID_W'(k);
            o_found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/intr_pending_ctrl.sv
// intr_pending_ctrl: edge-detects enabled interrupt lines, latches them as pending and
// presents the lowest pending ID to the core through a valid/ack handshake.
module intr_pending_ctrl
   import intr_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_IRQ-1:0] intr_lines_i,
   input  logic [NUM_IRQ-1:0] intr_enable_i,
   output logic               irq_valid_o,
   output logic [ID_W-1:0]    irq_id_o,
   input  logic               irq_ack_i,
   output logic [NUM_IRQ-1:0] pending_o,
   output logic               pending_any_o
);
   logic [NUM_IRQ-1:0] r_prev;
   logic [NUM_IRQ-1:0] r_pending;
   logic [ID_W-1:0]    r_id;
   irq_state_e         r_state;
   irq_state_e         w_next;
   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] w_clr;
   logic [ID_W-1:0]    w_enc_id;
   logic               w_found;
   logic               w_latch;

   intr_prio_enc u_enc (
      .i_vec   (r_pending),
      .o_id    (w_enc_id),
      .o_found (w_found)
   );

   assign w_rise = intr_lines_i & ~r_prev & intr_enable_i;

   always_comb begin
      w_next  = r_state;
      w_clr   = '0;
      w_latch = 1'b0;
      if (r_state == IRQ_IDLE) begin
         w_latch = w_found;
         w_next  = w_found ? IRQ_REQ : IRQ_IDLE;
      end else if (irq_ack_i) begin
         w_clr  = NUM_IRQ'(1) << r_id;
         w_next = IRQ_IDLE;
      end
   end

   // Rise is OR-ed after the clear so a re-edge in the ack cycle re-pends the line.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_prev    <= '0;
         r_pending <= '0;
         r_id      <= '0;
         r_state   <= IRQ_IDLE;
      end else begin
         r_prev    <= intr_lines_i;
         r_pending <= (r_pending & ~w_clr) | w_rise;
         r_state   <= w_next;
         if (w_latch) r_id <= w_enc_id;
      end
   end

   assign irq_valid_o   = (r_state == IRQ_REQ);
   assign irq_id_o      = r_id;
   assign pending_o     = r_pending;
   assign pending_any_o = |r_pending;
endmodule

// File: tb/tb_intr_pending_ctrl.sv
// tb_intr_pending_ctrl: table-driven vectors plus directed multi-cycle sequences.
module tb_intr_pending_ctrl;
   typedef struct {
      logic [127:0] lines;
      logic [127:0] en;
      logic         ack;
      logic         valid;
      logic [6:0]   id;
      logic [127:0] pend;
   } vec_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic [127:0] lines, en;
   logic         ack;
   logic         valid, any;
   logic [6:0]   id;
   logic [127:0] pend;
   int           n_checks = 0;
   int           n_err = 0;
   vec_t         tbl[$];
   logic [127:0] all1, nomask3, b127;

   intr_pending_ctrl dut (
      .clk           (clk),
      .resetn        (resetn),
      .intr_lines_i  (lines),
      .intr_enable_i (en),
      .irq_valid_o   (valid),
      .irq_id_o      (id),
      .irq_ack_i     (ack),
      .pending_o     (pend),
      .pending_any_o (any)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic expect_o(input string nm, input logic v, input logic [6:0] i, input logic [127:0] p);
      chk({nm, " valid"}, 128'(valid), 128'(v));
      if (v) chk({nm, " id"}, 128'(id), 128'(i));
      chk({nm, " pending"}, pend, p);
      chk({nm, " any"}, 128'(any), 128'(|p));
   endtask

   task automatic step(input logic [127:0] l, input logic [127:0] e, input logic a);
      lines = l;
      en    = e;
      ack   = a;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic [127:0] l, input logic [127:0] e, input logic a,
                               input logic v, input logic [6:0] i, input logic [127:0] p);
      vec_t r;
      r.lines = l; r.en = e; r.ack = a; r.valid = v; r.id = i; r.pend = p;
      return r;
   endfunction

   initial begin
      all1    = '1;
      nomask3 = ~(128'(1) << 3);
      b127    = 128'(1) << 127;
      // single pulse on lines 1,2 then two acks
      tbl.push_back(mk(128'h6, all1, 0, 0, 0, 128'h6));
      tbl.push_back(mk(128'h0, all1, 0, 1, 1, 128'h6));
      tbl.push_back(mk(128'h0, all1, 1, 0, 1, 128'h4));
      tbl.push_back(mk(128'h0, all1, 0, 1, 2, 128'h4));
      tbl.push_back(mk(128'h0, all1, 1, 0, 2, 128'h0));
      tbl.push_back(mk(128'h0, all1, 0, 0, 2, 128'h0));
      // masked line 3, then ack while idle
      tbl.push_back(mk(128'h8, nomask3, 0, 0, 2, 128'h0));
      tbl.push_back(mk(128'h0, nomask3, 0, 0, 2, 128'h0));
      tbl.push_back(mk(128'h0, nomask3, 0, 0, 2, 128'h0));
      tbl.push_back(mk(128'h0, all1, 1, 0, 2, 128'h0));
      // committed id 5 while line 0 arrives
      tbl.push_back(mk(128'h20, all1, 0, 0, 2, 128'h20));
      tbl.push_back(mk(128'h0, all1, 0, 1, 5, 128'h20));
      tbl.push_back(mk(128'h1, all1, 0, 1, 5, 128'h21));
      tbl.push_back(mk(128'h0, all1, 0, 1, 5, 128'h21));
      tbl.push_back(mk(128'h0, all1, 1, 0, 5, 128'h01));
      tbl.push_back(mk(128'h0, all1, 0, 1, 0, 128'h01));
      tbl.push_back(mk(128'h0, all1, 1, 0, 0, 128'h00));
      // enable dropped while in REQ
      tbl.push_back(mk(128'h200, all1, 0, 0, 0, 128'h200));
      tbl.push_back(mk(128'h0, '0, 0, 1, 9, 128'h200));
      tbl.push_back(mk(128'h0, '0, 0, 1, 9, 128'h200));
      tbl.push_back(mk(128'h0, '0, 1, 0, 9, 128'h0));

      resetn = 1'b0; lines = '0; en = '0; ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset id", 128'(id), 128'h0);
      expect_o("reset", 0, 0, '0);
      resetn = 1'b1;

      foreach (tbl[n]) begin
         step(tbl[n].lines, tbl[n].en, tbl[n].ack);
         chk($sformatf("vec%0d valid", n), 128'(valid), 128'(tbl[n].valid));
         chk($sformatf("vec%0d id", n), 128'(id), 128'(tbl[n].id));
         chk($sformatf("vec%0d pending", n), pend, tbl[n].pend);
         chk($sformatf("vec%0d any", n), 128'(any), 128'(|tbl[n].pend));
      end

      // level held high 10 cycles yields one request; re-edge after a low cycle yields another
      step(128'h80, all1, 0); expect_o("lvl set", 0, 0, 128'h80);
      step(128'h80, all1, 0); expect_o("lvl req", 1, 7, 128'h80);
      step(128'h80, all1, 1); expect_o("lvl ack", 0, 0, '0);
      for (int c = 0; c < 7; c++) begin
         step(128'h80, all1, 0); expect_o("lvl hold", 0, 0, '0);
      end
      step(128'h0, all1, 0);  expect_o("lvl low", 0, 0, '0);
      step(128'h80, all1, 0); expect_o("lvl reedge", 0, 0, 128'h80);
      step(128'h0, all1, 0);  expect_o("lvl req2", 1, 7, 128'h80);
      step(128'h0, all1, 1);  expect_o("lvl ack2", 0, 0, '0);

      // top line, with a re-edge landing in the ack cycle
      step(b127, all1, 0);   expect_o("l127 set", 0, 0, b127);
      step('0, all1, 0);     expect_o("l127 req", 1, 127, b127);
      step(b127, all1, 1);   expect_o("l127 ack+edge", 0, 0, b127);
      step('0, all1, 0);     expect_o("l127 req2", 1, 127, b127);
      step('0, all1, 1);     expect_o("l127 ack2", 0, 0, '0);

      // asynchronous reset while a request is presented
      step(128'h10, all1, 0);
      step('0, all1, 0);     expect_o("pre areset", 1, 4, 128'h10);
      #2 resetn = 1'b0;
      #1;
      chk("areset id", 128'(id), 128'h0);
      expect_o("areset", 0, 0, '0);
      @(negedge clk);
      resetn = 1'b1;
      step('0, all1, 0);     expect_o("post areset", 0, 0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
